// File: rtl/sprite_encoder_pkg.sv
// Shared types, sizes and colour-distance helpers for the sprite palette encoder.
package sprite_pkg;

    localparam int PAL_N  = 16;
    localparam int CH_W   = 4;
    localparam int DIST_W = 6;
    localparam int RGB_W  = 3 * CH_W;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_WRITE  = 2'd2
    } enc_state_e;

    typedef logic [PAL_N-1:0][RGB_W-1:0] palette_t;

    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Manhattan distance over the three 4-bit channels; never exceeds 45.
    function automatic logic [DIST_W-1:0] rgb_dist(input logic [RGB_W-1:0] a, input logic [RGB_W-1:0] b);
        return DIST_W'(abs_diff(a[3*CH_W-1:2*CH_W], b[3*CH_W-1:2*CH_W]))
             + DIST_W'(abs_diff(a[2*CH_W-1:CH_W],   b[2*CH_W-1:CH_W]))
             + DIST_W'(abs_diff(a[CH_W-1:0],        b[CH_W-1:0]));
    endfunction

    // Palette images are baked in and picked by file name, so no file loader is needed.
    function automatic palette_t pal_image(input logic doodle);
        palette_t p;
        for (int k = 0; k < PAL_N; k++) begin
            if (doodle) begin
                p[k] = 12'h888;
            end else begin
                p[k] = {3{4'(k)}};
            end
        end
        if (doodle) begin
            p[0] = 12'h000;
            p[1] = 12'hFFF;
            p[2] = 12'hF00;
            p[3] = 12'h222;
        end
        return p;
    endfunction

endpackage

// File: rtl/sprite_encoder_if.sv
// Pixel stream, display read port and optional palette write port of the sprite encoder.
interface sprite_encoder_if #(
    parameter int ADDRW = 12
);
    import sprite_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [RGB_W-1:0] i_rgb;
    logic             i_sof;
    logic             o_busy;
    logic             o_done;
    logic [ADDRW-1:0] i_rd_addr;
    logic [IDX_W-1:0] o_rd_pix;
`ifdef SPRITE_ENC_PAL_WR_EN
    logic             i_pal_we;
    logic [3:0]       i_pal_addr;
    logic [RGB_W-1:0] i_pal_data;
`endif

    modport master (
        output i_valid, i_rgb, i_sof, i_rd_addr,
`ifdef SPRITE_ENC_PAL_WR_EN
        output i_pal_we, i_pal_addr, i_pal_data,
`endif
        input  o_ready, o_busy, o_done, o_rd_pix
    );

    modport slave (
        input  i_valid, i_rgb, i_sof, i_rd_addr,
`ifdef SPRITE_ENC_PAL_WR_EN
        input  i_pal_we, i_pal_addr, i_pal_data,
`endif
        output o_ready, o_busy, o_done, o_rd_pix
    );

endinterface

// File: rtl/sprite_encoder_ram_sdp.sv
// Simple dual-port sprite RAM: one write port, one registered read port (read-before-write).
module sprite_ram_sdp #(
    parameter int DEPTH  = 4096,
    parameter int ADDRW  = 12,
    parameter int DATA_W = 4
) (
    input  logic              i_clk_25,
    input  logic              i_rst_n,
    input  logic              we,
    input  logic [ADDRW-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDRW-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage write; contents survive reset.
    always_ff @(posedge i_clk_25) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; a same-address write in this cycle is not yet visible.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sprite_encoder.sv
// Quantizes 12-bit RGB pixels to the nearest of 16 palette entries and stores the index in sprite RAM.
// Optional runtime palette write port: define SPRITE_ENC_PAL_WR_EN.
module sprite_encoder
    import sprite_pkg::*;
#(
    parameter int    WIDTH        = 64,
    parameter int    HEIGHT       = 64,
    parameter int    ADDRW        = 12,
    parameter string PALETTE_FILE = "doodle_palette.mem"
) (
    input logic             i_clk_25,
    input logic             i_rst_n,
    sprite_encoder_if.slave bus
);

    localparam int               DEPTH      = WIDTH * HEIGHT;
    localparam logic [ADDRW-1:0] LAST_ADDR  = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW-1:0] ADDR_ZERO  = {ADDRW{1'b0}};
    localparam logic [ADDRW-1:0] ADDR_ONE   = ADDRW'(1);
    localparam logic [3:0]       K_LAST     = 4'(PAL_N - 1);
    localparam bit               PAL_DOODLE = (PALETTE_FILE == "doodle_palette.mem");
    localparam palette_t         PAL_INIT   = pal_image(PAL_DOODLE);

    enc_state_e        state_r;
    enc_state_e        state_nxt_s;
    logic [3:0]        k_r;
    logic [RGB_W-1:0]  pix_r;
    logic [IDX_W-1:0]  best_idx_r;
    logic [DIST_W-1:0] best_dist_r;
    logic [ADDRW-1:0]  wr_addr_r;
    logic              done_r;
    logic              ready_s;
    logic              accept_s;
    logic [RGB_W-1:0]  pal_entry_s;
    logic [DIST_W-1:0] dist_s;
    logic              take_s;
    logic              ram_we_s;
    logic [IDX_W-1:0]  rd_pix_s;

`ifdef SPRITE_ENC_PAL_WR_EN
    palette_t pal_r = PAL_INIT;

    // Palette updates land only while idle so a search never sees a half-changed table.
    always_ff @(posedge i_clk_25) begin
        if (bus.i_pal_we && (state_r == ST_IDLE)) begin
            pal_r[bus.i_pal_addr] <= bus.i_pal_data;
        end
    end

    assign ready_s     = (state_r == ST_IDLE) && !bus.i_pal_we;
    assign pal_entry_s = pal_r[k_r];
`else
    assign ready_s     = (state_r == ST_IDLE);
    assign pal_entry_s = PAL_INIT[k_r];
`endif

    assign accept_s = bus.i_valid && ready_s;
    assign dist_s   = rgb_dist(pix_r, pal_entry_s);
    // Strict compare keeps the lowest index on ties; entry 0 always seeds the search.
    assign take_s   = (k_r == 4'd0) || (dist_s < best_dist_r);
    assign ram_we_s = (state_r == ST_WRITE);

    // FSM state register.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SEARCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (k_r == K_LAST) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_WRITE: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Pixel latch, nearest-entry search and write-address sequencing.
    always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_r       <= {RGB_W{1'b0}};
            k_r         <= 4'd0;
            best_idx_r  <= {IDX_W{1'b0}};
            best_dist_r <= {DIST_W{1'b0}};
            wr_addr_r   <= ADDR_ZERO;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        pix_r <= bus.i_rgb;
                        k_r   <= 4'd0;
                        if (bus.i_sof) begin
                            wr_addr_r <= ADDR_ZERO;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (take_s) begin
                        best_idx_r  <= k_r;
                        best_dist_r <= dist_s;
                    end
                    k_r <= k_r + 4'd1;
                end
                ST_WRITE: begin
                    done_r    <= (wr_addr_r == LAST_ADDR);
                    wr_addr_r <= (wr_addr_r == LAST_ADDR) ? ADDR_ZERO : (wr_addr_r + ADDR_ONE);
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    sprite_ram_sdp #(
        .DEPTH  (DEPTH),
        .ADDRW  (ADDRW),
        .DATA_W (IDX_W)
    ) u_ram (
        .i_clk_25 (i_clk_25),
        .i_rst_n  (i_rst_n),
        .we       (ram_we_s),
        .wr_addr  (wr_addr_r),
        .wr_data  (best_idx_r),
        .rd_addr  (bus.i_rd_addr),
        .rd_data  (rd_pix_s)
    );

    assign bus.o_ready  = ready_s;
    assign bus.o_busy   = (state_r != ST_IDLE);
    assign bus.o_done   = done_r;
    assign bus.o_rd_pix = rd_pix_s;

endmodule

// File: tb/tb_sprite_encoder.sv
// Scoreboard bench for sprite_encoder: random pixels against a nearest-colour reference model.
module tb_sprite_encoder;

    localparam int W     = 64;
    localparam int H     = 64;
    localparam int AW    = 12;
    localparam int DEPTH = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    sprite_encoder_if #(.ADDRW(AW)) bus ();

    sprite_encoder #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .ADDRW        (AW),
        .PALETTE_FILE ("doodle_palette.mem")
    ) dut (
        .i_clk_25 (clk),
        .i_rst_n  (rst_n),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int pal [16];
    int ref_ram [DEPTH];
    bit ref_ok  [DEPTH];
    int ref_wa = 0;

    int    rd_q [$];
    int    done_q [$];
    string chk_name_q [$];
    int    chk_act_q [$];
    int    chk_exp_q [$];
    logic  rd_req = 1'b0;
    logic  rd_fire_d = 1'b0;

    function automatic int ad(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Reference: scan the palette, keep the first entry with the smallest distance.
    function automatic int nearest(input int rgb);
        int best = 0;
        int bd = 1000;
        for (int k = 0; k < 16; k++) begin
            int d;
            d = ad((rgb >> 8) & 15, (pal[k] >> 8) & 15) + ad((rgb >> 4) & 15, (pal[k] >> 4) & 15)
              + ad(rgb & 15, pal[k] & 15);
            if (d < bd) begin
                bd = d;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        chk_name_q.push_back(name);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(exp);
    endtask

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_fire_d <= rd_req;
    end

    // Monitor: drains queued checks, read-port results and o_done pulses.
    always @(negedge clk) begin
        string n;
        int a;
        int e;
        while (chk_name_q.size() > 0) begin
            n = chk_name_q.pop_front();
            a = chk_act_q.pop_front();
            e = chk_exp_q.pop_front();
            tests++;
            if (a != e) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
            end
        end
        if (rd_fire_d) begin
            tests++;
            if (rd_q.size() == 0) begin
                fails++;
                $display("FAIL rd_pix: read result with no expectation queued (cycle %0d)", cyc);
            end else begin
                e = rd_q.pop_front();
                if (int'(bus.o_rd_pix) != e) begin
                    fails++;
                    $display("FAIL rd_pix: got %0d expected %0d (cycle %0d)", bus.o_rd_pix, e, cyc);
                end
            end
        end
        if (bus.o_done === 1'b1) begin
            tests++;
            if (done_q.size() == 0) begin
                fails++;
                $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = done_q.pop_front();
                if (cyc != e) begin
                    fails++;
                    $display("FAIL done: pulse at cycle %0d expected cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic read_check(input int addr);
        bus.i_rd_addr = AW'(addr);
        rd_q.push_back(ref_ram[addr]);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", int'(bus.o_ready), 1);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_rd_pix", int'(bus.o_rd_pix), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ref_wa = 0;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.o_ready), 1);
    endtask

    // Called on a negedge with the encoder idle; returns on the negedge where o_ready is back.
    task automatic send_pixel(input int rgb, input bit sof, input bit collide);
        int exp_idx, wa, old_v, low, t_acc;
        bit old_ok;
        chk("ready_idle", int'(bus.o_ready), 1);
        exp_idx = nearest(rgb);
        bus.i_valid = 1'b1;
        bus.i_rgb   = 12'(rgb);
        bus.i_sof   = sof;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        t_acc = cyc;
        if (sof) ref_wa = 0;
        wa     = ref_wa;
        old_v  = ref_ram[wa];
        old_ok = ref_ok[wa];
        ref_ram[wa] = exp_idx;
        ref_ok[wa]  = 1'b1;
        if (wa == DEPTH - 1) done_q.push_back(t_acc + 17);
        ref_wa = (wa + 1) % DEPTH;
        low = 0;
        while (bus.o_ready !== 1'b1 && low < 40) begin
            low++;
            if (low == 1) chk("busy", int'(bus.o_busy), 1);
            if (collide && old_ok && low == 17) begin
                bus.i_rd_addr = AW'(wa);
                rd_q.push_back(old_v);
                rd_req = 1'b1;
            end
            @(negedge clk);
            rd_req = 1'b0;
        end
        chk("ready_low_cycles", low, 17);
        chk("busy_clear", int'(bus.o_busy), 0);
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int base;
        for (int k = 0; k < 16; k++) pal[k] = 'h888;
        pal[0] = 'h000; pal[1] = 'hFFF; pal[2] = 'hF00; pal[3] = 'h222;
        bus.i_valid = 1'b0;
        bus.i_rgb = 12'h000;
        bus.i_sof = 1'b0;
        bus.i_rd_addr = '0;
`ifdef SPRITE_ENC_PAL_WR_EN
        bus.i_pal_we = 1'b0;
        bus.i_pal_addr = 4'd0;
        bus.i_pal_data = 12'h000;
`endif
        @(negedge clk);
        do_reset();

        // Exact match, then ties resolving to the lowest index.
        send_pixel('hF00, 1'b1, 1'b0);
        read_check(0);
        send_pixel('h111, 1'b0, 1'b0);
        send_pixel('h333, 1'b0, 1'b0);
        read_check(1);
        read_check(2);

        base = ref_wa;
        for (int i = 0; i < 30; i++) send_pixel(int'($urandom_range(4095, 0)), 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) read_check(base + i);

        // Full frame: exactly one o_done, with collision reads at the first addresses.
        for (int i = 0; i < DEPTH; i++) send_pixel('hF00, (i == 0), (i < 3));
        read_check(2047);
        read_check(DEPTH - 1);
        send_pixel('hFFF, 1'b0, 1'b0);
        read_check(0);

        // SOF in mid-frame restarts at address 0.
        for (int i = 0; i < 10; i++) begin
            v = (ref_wa == 7) ? 'h222 : int'($urandom_range(4095, 0));
            send_pixel(v, 1'b0, 1'b0);
        end
        send_pixel('h000, 1'b1, 1'b0);
        send_pixel(int'($urandom_range(4095, 0)), 1'b0, 1'b1);
        read_check(0);
        read_check(1);
        for (int i = 0; i < 5; i++) send_pixel(int'($urandom_range(4095, 0)), 1'b0, 1'b0);
        chk("addr_before_abort", ref_wa, 7);

        // Reset while searching: the in-flight pixel must not be written.
        bus.i_valid = 1'b1;
        bus.i_rgb = 12'hFFF;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_mid_search", int'(bus.o_busy), 1);
        do_reset();
        read_check(7);
        send_pixel('h123, 1'b0, 1'b0);
        read_check(0);

`ifdef SPRITE_ENC_PAL_WR_EN
        bus.i_pal_we = 1'b1;
        bus.i_pal_addr = 4'd4;
        bus.i_pal_data = 12'h0F0;
        #1;
        chk("pal_we_ready", int'(bus.o_ready), 0);
        @(negedge clk);
        bus.i_pal_we = 1'b0;
        pal[4] = 'h0F0;
        send_pixel('h0A0, 1'b0, 1'b0);
        read_check(ref_wa - 1);
`endif

        repeat (3) @(negedge clk);
        chk("done_pending", done_q.size(), 0);
        chk("rd_pending", rd_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
